woof_fifo_drain: RTL
====================

// Module: woof_fifo_drain
// PURPOSE
//   Read-side consumer for a first-word-fallthrough FIFO. Pops WIDTH-bit words and
//   serializes each into WIDTH/8 bytes on a valid/ready byte stream.
//   Sits between a woof FIFO's read port and a byte-wide sink (UART TX, SPI shifter).
//   Sustains one byte per clock with no bubble between words.
// PARAMETERS
//   WIDTH      32  FIFO word width. Must be a multiple of 8 and >= 8. NB = WIDTH/8.
//   MSB_FIRST  0   0: byte[7:0] goes out first. 1: byte[WIDTH-1:WIDTH-8] goes out first.
//   CNT_WIDTH  16  Width of the bytes-sent counter.
// PORTS
//   clock          in   1          Rising-edge clock.
//   reset_n        in   1          Synchronous, active-low reset.
//   enable         in   1          Permits starting a new word. Checked only at word boundaries.
//   fifo_rd_en     out  1          Pop strobe to the FIFO, one cycle per word.
//   fifo_rd_data   in   WIDTH      FIFO head word. Valid whenever !fifo_rd_empty (fallthrough).
//   fifo_rd_empty  in   1          FIFO empty flag.
//   out_valid      out  1          A byte is presented on out_data.
//   out_data       out  8          Byte being presented.
//   out_last       out  1          Marks the final byte of the current word. Qualified by out_valid.
//   out_ready      in   1          Sink accepts the byte when out_valid && out_ready.
//   busy           out  1          1 while a word is held (state SEND).
//   bytes_sent     out  CNT_WIDTH  Count of accepted bytes. Wraps modulo 2^CNT_WIDTH.
// BEHAVIOUR
//   States
//   - IDLE: no word held; out_valid = 0.
//   - SEND: word held in shift register; byte index idx runs 0..NB-1.
//   Load condition: load = enable && !fifo_rd_empty && (IDLE || (SEND && out_ready && idx == NB-1)).
//   fifo_rd_en
//   - Combinational; equals load.
//   - Never asserted while fifo_rd_empty = 1.
//   - At most one pulse per word.
//   On load
//   - fifo_rd_data is captured into the shift register on the same edge that pops it.
//   - idx <= 0; state <= SEND.
//   IDLE -> SEND
//   - Transition on load.
//   - out_valid rises the cycle after load, i.e. 1 cycle of latency from the fallthrough word.
//   In SEND
//   - out_valid = 1.
//   - out_data = byte idx in the configured order.
//   - out_last = (idx == NB-1).
//   While out_valid && !out_ready
//   - out_data, out_last and idx hold stable.
//   - No pop occurs.
//   Handshake in SEND
//   - Accept when idx < NB-1: idx <= idx + 1.
//   - Accept when idx == NB-1 and load = 1: next word loads on the same edge; no idle cycle.
//   - Accept when idx == NB-1 and load = 0: state <= IDLE.
//   enable
//   - Deasserting it mid-word does not abort. The current word finishes, then the block stops at the boundary.
//   - Asserting it while IDLE with data present gives fifo_rd_en in the same cycle.
//   bytes_sent increments by 1 on every accepted byte (out_valid && out_ready).
//   Reset (reset_n = 0 at a clock edge) clears:
//   - state = IDLE, idx = 0, shift register = 0, bytes_sent = 0.
//   - Outputs: out_valid = 0, out_last = 0, busy = 0, out_data = 0, fifo_rd_en = 0.
//   - fifo_rd_en stays 0 for the whole cycle in which reset_n is low.
//   Reset mid-word: the partially sent word is discarded; it is already popped and is not re-read.
//   NB == 1 (WIDTH = 8): every byte has out_last = 1; one pop per accepted byte.
// TESTING
//   1. Reset: hold reset_n = 0 for 3 clocks with FIFO non-empty -> fifo_rd_en = 0, out_valid = 0, bytes_sent = 0.
//   2. Single word: push 0x44332211, out_ready = 1, MSB_FIRST = 0 -> bytes 11,22,33,44 on consecutive
//      cycles; out_last only on 44; one fifo_rd_en pulse; bytes_sent = 4.
//   3. Back-to-back: 3 words queued, out_ready = 1 -> 12 consecutive valid cycles, no gap;
//      pops on cycles 0, 4 and 8 relative to the first pop.
//   4. Backpressure: toggle out_ready randomly -> out_data stable while stalled; byte order intact;
//      no pop before the final byte of a word is accepted.
//   5. enable = 0 during byte 1 of word A with word B queued -> A completes; B not popped until enable = 1.
//   6. MSB_FIRST = 1, word 0xA1B2C3D4 -> A1,B2,C3,D4. Then reset after byte 2 -> IDLE next cycle and
//      bytes_sent = 0.

Source files
------------

// File: rtl/woof_fifo_drain.sv
// woof_fifo_drain
//   Read-side consumer for a first-word-fallthrough FIFO. Each popped WIDTH-bit word is
//   serialized into WIDTH/8 bytes on a valid/ready byte stream, one byte per clock, with
//   no bubble between consecutive words.
//
// Parameters
//   WIDTH      FIFO word width, a multiple of 8 and >= 8 (NB = WIDTH/8 bytes per word)
//   MSB_FIRST  0: byte[7:0] leaves first; 1: byte[WIDTH-1:WIDTH-8] leaves first
//   CNT_WIDTH  width of the accepted-byte counter
//
// Ports
//   clock, reset_n   rising-edge clock, synchronous active-low reset
//   enable           permits starting a new word; only looked at on word boundaries
//   fifo_rd_en       pop strobe (combinational), one cycle per word
//   fifo_rd_data     FIFO head word, valid whenever !fifo_rd_empty
//   fifo_rd_empty    FIFO empty flag
//   out_valid        byte present on out_data
//   out_data         byte being presented
//   out_last         final byte of the current word (qualified by out_valid)
//   out_ready        sink accepts the byte when out_valid && out_ready
//   busy             a word is held
//   bytes_sent       accepted-byte count, wraps modulo 2^CNT_WIDTH
module woof_fifo_drain #(
   parameter int unsigned WIDTH     = 32,
   parameter bit          MSB_FIRST = 1'b0,
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 enable,
   output logic                 fifo_rd_en,
   input  logic [WIDTH-1:0]     fifo_rd_data,
   input  logic                 fifo_rd_empty,
   output logic                 out_valid,
   output logic [7:0]           out_data,
   output logic                 out_last,
   input  logic                 out_ready,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] bytes_sent
);

   localparam int unsigned NB   = WIDTH / 8;
   localparam int unsigned IdxW = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NB - 1);

   if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_bad_width
      $error("woof_fifo_drain: WIDTH must be a multiple of 8 and >= 8");
   end

   typedef enum logic [0:0] {StIdle, StSend} state_e;

   state_e               state_q, state_d;
   logic [IdxW-1:0]      idx_q, idx_d;
   logic [WIDTH-1:0]     shift_q, shift_d;
   logic [WIDTH-1:0]     shift_next;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 at_last;
   logic                 accept;
   logic                 load;

   // The outgoing byte always sits at the head end of the shift register, so the register
   // moves one byte towards that end on every accepted byte.
   assign shift_next = MSB_FIRST ? (shift_q << 8) : (shift_q >> 8);

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      shift_d    = shift_q;
      cnt_d      = cnt_q;
      at_last    = (idx_q == LastIdx);
      accept     = (state_q == StSend) && out_ready;
      // reset_n gates the pop so nothing leaves the FIFO during a reset cycle.
      load       = reset_n && enable && !fifo_rd_empty &&
                   ((state_q == StIdle) || (accept && at_last));
      fifo_rd_en = load;
      out_valid  = (state_q == StSend);
      busy       = (state_q == StSend);
      out_last   = (state_q == StSend) && at_last;
      out_data   = MSB_FIRST ? shift_q[WIDTH-1 -: 8] : shift_q[7:0];
      bytes_sent = cnt_q;

      if (accept) begin
         cnt_d   = cnt_q + CNT_WIDTH'(1);
         shift_d = shift_next;
         if (at_last) begin
            state_d = StIdle;
            idx_d   = '0;
         end else begin
            idx_d = idx_q + IdxW'(1);
         end
      end

      // A load on the final accepted byte overrides the return to idle: no bubble.
      if (load) begin
         shift_d = fifo_rd_data;
         idx_d   = '0;
         state_d = StSend;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= StIdle;
         idx_q   <= '0;
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule
